// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared ISA widths used to default the fetch queue parameters, plus a
//   small helper used to size queue pointers.
//   No ports (package).
package fetch_queue_pkg;

   // Shared ISA definitions
   localparam int LEN_ADDRESS     = 32;
   localparam int LEN_INSTRUCTION = 32;

   // Pointer width for a power-of-two queue depth
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem
//   Entry storage for the fetch queue: DEPTH x WIDTH register array with one
//   synchronous write port and one asynchronous (combinational) read port.
//   Ports:
//     clk     - rising-edge clock
//     i_we    - write enable
//     i_waddr - write index
//     i_wdata - write data
//     i_raddr - read index
//     o_rdata - read data (combinational from i_raddr)
//   Storage carries no reset; validity is tracked by the controller.
module fetch_queue_mem
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int AW   = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch queue. Generates sequential fetch addresses to a
//   combinational instruction memory and buffers {pc+PC_STEP, instruction}
//   pairs for the consumer. Supports freeze (consumer stall), flush and
//   branch redirect.
//   Ports:
//     clk             - rising-edge clock
//     rst             - asynchronous active-high reset
//     freeze          - consumer stall; head not popped while high
//     flush           - discard all queued entries (fetch_pc held)
//     is_branch       - redirect fetch to branch_address, clears queue
//     branch_address  - branch target
//     imem_addr       - current fetch address
//     imem_rdata      - instruction at imem_addr (same cycle)
//     out_valid       - head entry present
//     out_pc          - head fetch address + PC_STEP (0 when empty)
//     out_instruction - head instruction (0 when empty)
//     count           - occupancy
//     full            - count == DEPTH
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int ADDR_W  = LEN_ADDRESS,
   parameter int INSTR_W = LEN_INSTRUCTION,
   parameter int DEPTH   = 4,
   parameter int PC_STEP = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   freeze,
   input  logic                   flush,
   input  logic                   is_branch,
   input  logic [ADDR_W-1:0]      branch_address,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic [INSTR_W-1:0]     imem_rdata,
   output logic                   out_valid,
   output logic [ADDR_W-1:0]      out_pc,
   output logic [INSTR_W-1:0]     out_instruction,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_valid;
   logic              w_full;
   logic              w_redirect;
   logic              w_pop;
   logic              w_push;
   logic [ADDR_W-1:0] w_next_seq_pc;
   logic [ENT_W-1:0]  w_wdata;
   logic [ENT_W-1:0]  w_rdata;

   assign w_valid    = (r_count != '0);
   assign w_full     = (r_count == CNT_W'(DEPTH));
   // Flush and branch both empty the queue, so neither push nor pop happens
   assign w_redirect = flush | is_branch;
   assign w_pop      = w_valid & ~freeze & ~w_redirect;
   // A pop frees a slot in the same cycle, so a full queue can still accept
   assign w_push     = (~w_full | w_pop) & ~w_redirect;

   assign w_next_seq_pc = r_fetch_pc + ADDR_W'(PC_STEP);
   assign w_wdata       = {w_next_seq_pc, imem_rdata};

   // Fetch PC: branch beats sequential increment; flush alone holds it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= '0;
      end else if (is_branch) begin
         r_fetch_pc <= branch_address;
      end else if (w_push) begin
         r_fetch_pc <= w_next_seq_pc;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_redirect) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign imem_addr       = r_fetch_pc;
   assign out_valid       = w_valid;
   assign out_pc          = w_valid ? w_rdata[ENT_W-1 -: ADDR_W] : '0;
   assign out_instruction = w_valid ? w_rdata[INSTR_W-1:0]       : '0;
   assign count           = r_count;
   assign full            = w_full;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT (DEPTH=4) ----------------
   logic        rst;
   logic        freeze;
   logic        flush;
   logic        is_branch;
   logic [31:0] branch_address;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instruction;
   logic [2:0]  count;
   logic        full;

   assign imem_rdata = 32'hE000_0000 + imem_addr;

   fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .PC_STEP(4)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .is_branch(is_branch), .branch_address(branch_address),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_pc(out_pc), .out_instruction(out_instruction),
      .count(count), .full(full)
   );

   // ---------------- second DUT (DEPTH=2) ----------------
   logic        rst2;
   logic        freeze2;
   logic        flush2 = 1'b0;
   logic        is_branch2 = 1'b0;
   logic [31:0] branch_address2 = 32'h0;
   logic [31:0] imem_addr2;
   logic [31:0] imem_rdata2;
   logic        out_valid2;
   logic [31:0] out_pc2;
   logic [31:0] out_instruction2;
   logic [1:0]  count2;
   logic        full2;

   assign imem_rdata2 = 32'hE000_0000 + imem_addr2;

   fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(2), .PC_STEP(4)) dut2 (
      .clk(clk), .rst(rst2), .freeze(freeze2), .flush(flush2),
      .is_branch(is_branch2), .branch_address(branch_address2),
      .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .out_valid(out_valid2), .out_pc(out_pc2), .out_instruction(out_instruction2),
      .count(count2), .full(full2)
   );

   int n_total = 0;
   int n_bad   = 0;
   logic [31:0] expq[$];     // expected popped out_pc values, main DUT
   logic [31:0] exp2 = 32'h4; // next expected popped out_pc, DEPTH=2 DUT
   int pops2 = 0;
   bit  run2 = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // One clock of stimulus; inputs return to the quiet (frozen) state after.
   task automatic step(input logic fz, input logic fl, input logic br, input logic [31:0] ba);
      freeze = fz; flush = fl; is_branch = br; branch_address = ba;
      @(posedge clk); #1;
      freeze = 1'b1; flush = 1'b0; is_branch = 1'b0; branch_address = '0;
   endtask

   // Scoreboard monitor, main DUT: a pop is presented at the negedge before
   // the edge that consumes it.
   always @(negedge clk) begin
      if (!rst && out_valid && !freeze && !flush && !is_branch) begin
         if (expq.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_pop: got out_pc 0x%0h want no pop", out_pc);
         end else begin
            logic [31:0] e;
            logic [31:0] ei;
            e  = expq.pop_front();
            ei = 32'hE000_0000 + e - 32'h4;
            chk("pop_pc", {32'h0, out_pc}, {32'h0, e});
            chk("pop_instr", {32'h0, out_instruction}, {32'h0, ei});
         end
      end
   end

   // Monitor, DEPTH=2 DUT: popped pcs must be 4, 8, 12, ... exactly.
   always @(negedge clk) begin
      if (run2 && !rst2) begin
         if (count2 > 2'd2) chk("d2_count_le_2", {62'h0, count2}, 64'd2);
         if (out_valid2 && !freeze2) begin
            chk("d2_pop_pc", {32'h0, out_pc2}, {32'h0, exp2});
            chk("d2_pop_instr", {32'h0, out_instruction2}, {32'h0, 32'hE000_0000 + exp2 - 32'h4});
            exp2  = exp2 + 32'h4;
            pops2 = pops2 + 1;
         end
      end
   end

   task automatic main_seq();
      rst = 1'b1; freeze = 1'b1; flush = 1'b0; is_branch = 1'b0; branch_address = '0;
      #2;
      chk("rst_count", {61'h0, count}, 64'd0);
      chk("rst_valid", {63'h0, out_valid}, 64'd0);
      chk("rst_imem_addr", {32'h0, imem_addr}, 64'd0);
      chk("rst_full", {63'h0, full}, 64'd0);
      chk("rst_out_pc", {32'h0, out_pc}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Fill with freeze held
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("fill_full", {63'h0, full}, 64'd1);
      chk("fill_count", {61'h0, count}, 64'd4);
      chk("fill_imem_addr", {32'h0, imem_addr}, 64'h10);
      chk("fill_out_pc", {32'h0, out_pc}, 64'h4);
      chk("fill_out_instr", {32'h0, out_instruction}, 64'hE000_0000);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("full_hold_imem_addr", {32'h0, imem_addr}, 64'h10);
      chk("full_hold_count", {61'h0, count}, 64'd4);

      // Pop+push while full
      expq.push_back(32'h4);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("fullpp_count", {61'h0, count}, 64'd4);
      chk("fullpp_out_pc", {32'h0, out_pc}, 64'h8);
      chk("fullpp_imem_addr", {32'h0, imem_addr}, 64'h14);

      expq.push_back(32'h8); expq.push_back(32'hC); expq.push_back(32'h10);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("stream_imem_addr", {32'h0, imem_addr}, 64'h20);
      chk("stream_out_pc", {32'h0, out_pc}, 64'h14);

      // Flush alone
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("flush_count", {61'h0, count}, 64'd0);
      chk("flush_imem_addr", {32'h0, imem_addr}, 64'h20);
      chk("flush_valid", {63'h0, out_valid}, 64'd0);
      chk("flush_out_pc_zero", {32'h0, out_pc}, 64'd0);
      chk("flush_out_instr_zero", {32'h0, out_instruction}, 64'd0);

      // Refill to 3 then branch
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("refill_count", {61'h0, count}, 64'd3);
      chk("refill_out_pc", {32'h0, out_pc}, 64'h24);
      step(1'b1, 1'b0, 1'b1, 32'h100);
      chk("br_count", {61'h0, count}, 64'd0);
      chk("br_imem_addr", {32'h0, imem_addr}, 64'h100);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("br_out_pc", {32'h0, out_pc}, 64'h104);
      chk("br_out_instr", {32'h0, out_instruction}, 64'hE000_0100);
      chk("br_count1", {61'h0, count}, 64'd1);

      // Push+pop with count==1
      expq.push_back(32'h104);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("c1pp_valid", {63'h0, out_valid}, 64'd1);
      chk("c1pp_count", {61'h0, count}, 64'd1);
      chk("c1pp_out_pc", {32'h0, out_pc}, 64'h108);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("pre_rst_count", {61'h0, count}, 64'd2);

      // Asynchronous reset mid-cycle
      #3; rst = 1'b1;
      #1;
      chk("arst_valid", {63'h0, out_valid}, 64'd0);
      chk("arst_count", {61'h0, count}, 64'd0);
      chk("arst_imem_addr", {32'h0, imem_addr}, 64'd0);
      chk("arst_out_pc", {32'h0, out_pc}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("post_rst_out_pc", {32'h0, out_pc}, 64'h4);
      chk("post_rst_instr", {32'h0, out_instruction}, 64'hE000_0000);

      // fetch_pc wraps modulo 2^32
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      chk("wrap_imem_addr", {32'h0, imem_addr}, 64'hFFFF_FFFC);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("wrap_out_pc", {32'h0, out_pc}, 64'h0);
      chk("wrap_valid", {63'h0, out_valid}, 64'd1);
      chk("wrap_instr", {32'h0, out_instruction}, 64'hDFFF_FFFC);
      chk("wrap_imem_addr2", {32'h0, imem_addr}, 64'h0);
   endtask

   task automatic d2_seq();
      rst2 = 1'b1; freeze2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0;
      run2 = 1'b1;
      for (int i = 0; i < 100; i++) begin
         freeze2 = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      freeze2 = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      fork
         main_seq();
         d2_seq();
      join
      chk("scoreboard_drained", 64'(expq.size()), 64'd0);
      chk("d2_enough_pops", {63'h0, (pops2 >= 10)}, 64'd1);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_fetch_queue
